matvec_engine: RTL and testbench

MATVEC_ENGINE -- requirements
Module: matvec_engine

---
 rtl/matvec_engine.sv | 182 ++++++++++++++++++
 tb/tb_matvec_engine.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_engine.sv
// Matrix-vector multiply engine: ROWS parallel MAC lanes, one column per cycle,
// results latched at completion and read back through a row-select port.
module matvec_engine #(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8,
    parameter int unsigned DW   = 8,
    parameter int unsigned AW   = 24,
    localparam int unsigned ADDR_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              signed_mode,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    input  logic [ROW_W-1:0]  rd_row,
    output logic [AW-1:0]     rd_data
);

    localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned PW     = 2 * DW;
    localparam int unsigned AEXT_W = ADDR_W + 1;
    localparam int unsigned REXT_W = ROW_W + 1;
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
    localparam logic [AEXT_W-1:0] A_SIZE   = AEXT_W'(ROWS * COLS);
    localparam logic [REXT_W-1:0] R_SIZE   = REXT_W'(ROWS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        FINISH  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             mode_q, mode_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [AW-1:0]    acc_q [ROWS];
    logic [AW-1:0]    acc_d [ROWS];
    logic [AW-1:0]    res_q [ROWS];
    logic [AW-1:0]    res_d [ROWS];
    logic [DW-1:0]    a_q   [ROWS*COLS];
    logic [DW-1:0]    b_q   [COLS];

    logic [AW-1:0]    prod_c  [ROWS];
    logic [AW:0]      sum_c   [ROWS];
    logic             any_ovf_c;
    logic             a_addr_ok_c;
    logic             row_ok_c;

    // Operand writes are blocked only while lanes are consuming columns
    assign a_addr_ok_c = ({1'b0, wr_addr} < A_SIZE);

    // Operand storage: A matrix (row-major) and B vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ROWS * COLS); i++) a_q[i] <= '0;
            for (int i = 0; i < int'(COLS); i++) b_q[i] <= '0;
        end else if (wr_en && (state_q != COMPUTE)) begin
            if (!wr_sel) begin
                if (a_addr_ok_c) a_q[wr_addr] <= wr_data;
            end else begin
                b_q[wr_addr[COL_W-1:0]] <= wr_data;
            end
        end
    end

    // Per-lane product for the current column, extended to AW and added to the accumulator
    always_comb begin
        logic [ADDR_W-1:0]   idx;
        logic signed [PW-1:0] sprod;
        logic [PW-1:0]        uprod;
        logic                 lane_ovf;
        any_ovf_c = 1'b0;
        for (int r = 0; r < int'(ROWS); r++) begin
            idx   = ADDR_W'(r * int'(COLS)) + ADDR_W'(col_q);
            sprod = PW'($signed(a_q[idx])) * PW'($signed(b_q[col_q]));
            uprod = PW'(a_q[idx]) * PW'(b_q[col_q]);
            if (mode_q) begin
                prod_c[r] = AW'(sprod);
            end else begin
                prod_c[r] = AW'(uprod);
            end
            sum_c[r] = {1'b0, acc_q[r]} + {1'b0, prod_c[r]};
            if (mode_q) begin
                lane_ovf = (acc_q[r][AW-1] == prod_c[r][AW-1]) &&
                           (sum_c[r][AW-1] != acc_q[r][AW-1]);
            end else begin
                lane_ovf = sum_c[r][AW];
            end
            any_ovf_c = any_ovf_c | lane_ovf;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        for (int r = 0; r < int'(ROWS); r++) begin
            acc_d[r] = acc_q[r];
            res_d[r] = res_q[r];
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COMPUTE;
                    col_d   = '0;
                    mode_d  = signed_mode;
                    ovf_d   = 1'b0;
                    for (int r = 0; r < int'(ROWS); r++) acc_d[r] = '0;
                end
            end
            COMPUTE: begin
                for (int r = 0; r < int'(ROWS); r++) acc_d[r] = sum_c[r][AW-1:0];
                if (any_ovf_c) ovf_d = 1'b1;
                if (col_q == COL_LAST) begin
                    state_d = FINISH;
                    col_d   = '0;
                    for (int r = 0; r < int'(ROWS); r++) res_d[r] = sum_c[r][AW-1:0];
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == COMPUTE);
        done_d = (state_d == FINISH);
    end

    // Control, accumulator and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            mode_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int r = 0; r < int'(ROWS); r++) begin
                acc_q[r] <= '0;
                res_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int r = 0; r < int'(ROWS); r++) begin
                acc_q[r] <= acc_d[r];
                res_q[r] <= res_d[r];
            end
        end
    end

    // Result readback; out-of-range rows read as zero
    assign row_ok_c = ({1'b0, rd_row} < R_SIZE);
    assign rd_data  = row_ok_c ? res_q[rd_row] : '0;

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_matvec_engine.sv
// Bench for matvec_engine: directed scenarios plus random jobs, checked against
// an arithmetic model of the matrix-vector product (24-bit and 16-bit instances).
module tb_matvec_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic        wr_sel;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        signed_mode;
    logic        start;
    logic [2:0]  rd_row;
    logic        busy, done, ovf;
    logic [23:0] rd_data;
    logic        busy16, done16, ovf16;
    logic [15:0] rd_data16;

    int checks = 0;
    int errors = 0;
    int ma [64];
    int mb [8];

    matvec_engine u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .signed_mode(signed_mode), .start(start), .busy(busy),
        .done(done), .ovf(ovf), .rd_row(rd_row), .rd_data(rd_data)
    );

    matvec_engine #(.AW(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .signed_mode(signed_mode), .start(start), .busy(busy16),
        .done(done16), .ovf(ovf16), .rd_row(rd_row), .rd_data(rd_data16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Dot product of row r with B, wrapped to aw bits; ov reports any out-of-range partial sum
    function automatic longint model_row(input int r, input int aw, input bit sm, output bit ov);
        longint lim = longint'(1) << aw;
        longint acc = 0;
        longint a, b, s;
        ov = 1'b0;
        for (int c = 0; c < 8; c++) begin
            a = ma[r*8 + c];
            b = mb[c];
            if (sm) begin
                if (a > 127) a -= 256;
                if (b > 127) b -= 256;
            end
            s = acc + a * b;
            if (sm) begin
                if (s >= lim / 2 || s < -(lim / 2)) ov = 1'b1;
                acc = ((s % lim) + lim) % lim;
                if (acc >= lim / 2) acc -= lim;
            end else begin
                if (s >= lim) ov = 1'b1;
                acc = s % lim;
            end
        end
        return acc & (lim - 1);
    endfunction

    task automatic wr(input bit sel, input int addr, input int data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 6'(addr);
        wr_data = 8'(data);
        tick();
        wr_en = 1'b0;
        if (sel) mb[addr % 8] = data;
        else     ma[addr] = data;
    endtask

    task automatic fill(input int av, input int bv);
        for (int i = 0; i < 64; i++) wr(1'b0, i, av);
        for (int c = 0; c < 8; c++) wr(1'b1, c, bv);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 64; i++) wr(1'b0, i, int'($urandom_range(0, 255)));
        for (int c = 0; c < 8; c++) wr(1'b1, c, int'($urandom_range(0, 255)));
    endtask

    // Launch a job and check busy length, done timing and single done pulse
    task automatic run_job(input string tag, input bit sm, input bit disturb);
        int busy_cyc = 0;
        int done_at  = 0;
        signed_mode = sm;
        start = 1'b1;
        tick();
        signed_mode = ~sm;
        for (int i = 1; i <= 40 && done_at == 0; i++) begin
            if (busy) busy_cyc++;
            if (done) done_at = i;
            if (disturb && busy) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_sel  = 1'($urandom_range(0, 1));
                wr_addr = 6'($urandom);
                wr_data = 8'($urandom);
            end else begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            if (done_at == 0) tick();
        end
        check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'd8);
        check({tag, "_done_cycle"}, 32'(done_at), 32'd9);
        tick();
        check({tag, "_done_single"}, 32'({done, done16, busy}), 32'd0);
    endtask

    task automatic check_results(input string tag, input bit sm);
        bit o, ov24, ov16;
        longint e;
        ov24 = 1'b0;
        ov16 = 1'b0;
        for (int r = 0; r < 8; r++) begin
            rd_row = 3'(r);
            #1;
            e = model_row(r, 24, sm, o);
            ov24 |= o;
            check($sformatf("%s_r%0d", tag, r), 32'(rd_data), 32'(e));
            e = model_row(r, 16, sm, o);
            ov16 |= o;
            check($sformatf("%s_r%0d_aw16", tag, r), 32'(rd_data16), 32'(e));
        end
        check({tag, "_ovf"}, 32'(ovf), 32'(ov24));
        check({tag, "_ovf_aw16"}, 32'(ovf16), 32'(ov16));
    endtask

    initial begin
        int seen;
        int nd;
        bit sm;
        rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        signed_mode = 1'b0; start = 1'b0; rd_row = '0;
        for (int i = 0; i < 64; i++) ma[i] = 0;
        for (int c = 0; c < 8; c++) mb[c] = 0;

        // Reset state
        #3;
        check("rst_outputs", 32'({busy, done, ovf, busy16, done16, ovf16}), 32'd0);
        for (int r = 0; r < 8; r++) begin
            rd_row = 3'(r);
            #1;
            check($sformatf("rst_rd_r%0d", r), 32'(rd_data), 32'd0);
        end
        #20;
        rst_n = 1'b1;
        tick();

        // All ones: each row sums to 8
        fill(1, 1);
        run_job("ones", 1'b0, 1'b0);
        check_results("ones", 1'b0);
        rd_row = 3'd5;
        #1;
        check("ones_r5_const", 32'(rd_data), 32'd8);

        // A[r][c] = r+1, B[c] = c -> 28*(r+1)
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) wr(1'b0, r*8 + c, r + 1);
        for (int c = 0; c < 8; c++) wr(1'b1, c, c);
        run_job("ramp", 1'b0, 1'b0);
        check_results("ramp", 1'b0);
        rd_row = 3'd7;
        #1;
        check("ramp_r7_const", 32'(rd_data), 32'd224);

        // Signed: -1 * 2 over 8 columns -> -16
        fill(255, 2);
        run_job("sneg", 1'b1, 1'b0);
        check_results("sneg", 1'b1);
        rd_row = 3'd0;
        #1;
        check("sneg_const", 32'(rd_data), 32'hFFFFF0);

        // 255*255*8 wraps in the 16-bit instance and raises ovf
        fill(255, 255);
        run_job("sat", 1'b0, 1'b0);
        check_results("sat", 1'b0);
        check("sat_aw16_const", 32'(rd_data16), 32'd61448);
        check("sat_ovf16_const", 32'(ovf16), 32'd1);

        // Reset in the middle of a job
        fill(1, 1);
        signed_mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", 32'({busy, done, ovf, busy16, done16, ovf16}), 32'd0);
        for (int r = 0; r < 8; r++) begin
            rd_row = 3'(r);
            #1;
            check($sformatf("mid_rst_rd_r%0d", r), 32'({rd_data, rd_data16}), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 64; i++) ma[i] = 0;
        for (int c = 0; c < 8; c++) mb[c] = 0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy || done16) nd++;
            tick();
        end
        check("mid_no_done", 32'(nd), 32'd0);
        check_results("post_rst", 1'b0);
        fill(1, 1);
        run_job("restart", 1'b0, 1'b0);
        check_results("restart", 1'b0);

        // Start and writes during busy are ignored
        fill_rand();
        sm = 1'($urandom_range(0, 1));
        run_job("disturb", sm, 1'b1);
        check_results("disturb", sm);

        // Write on the start-accepting edge is seen by column 0
        fill_rand();
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd0; wr_data = 8'hA5;
        ma[0] = 165;
        run_job("wr_start", 1'b0, 1'b0);
        check_results("wr_start", 1'b0);

        // Start held high through FINISH relaunches in IDLE
        fill_rand();
        signed_mode = 1'b0;
        start = 1'b1;
        tick();
        seen = 0;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            if (done) seen = 1;
            else tick();
        end
        check("hold_done1", 32'(seen), 32'd1);
        tick();
        check("hold_idle", 32'(busy), 32'd0);
        tick();
        check("hold_relaunch", 32'(busy), 32'd1);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            if (done) seen = 1;
            else tick();
        end
        check("hold_done2", 32'(seen), 32'd1);
        tick();
        check_results("hold", 1'b0);

        // Random jobs in both modes
        for (int t = 0; t < 4; t++) begin
            fill_rand();
            sm = 1'(t % 2);
            run_job($sformatf("rnd%0d", t), sm, 1'b0);
            check_results($sformatf("rnd%0d", t), sm);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
